varm_core_p: RTL and testbench
==============================

VARM_CORE_P -- requirements
Module: varm_core_p

Interface
REQ-001 The block SHALL have parameter DW, default 8: datapath width in bits, legal range 4..32.
REQ-002 The block SHALL have parameter NREG, default 8: general register count, a power of two, minimum 4.
REQ-003 The block SHALL have parameter SDEPTH, default 4: call/data stack depth, minimum 2.
REQ-004 The block SHALL have the following ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- op_valid  in  1  instruction control word present.
- op_ready  out  1  block can accept a word.
- calu  in  4  ALU opcode.
- rd, rs1, rs2  in  log2(NREG) each  destination and source register indices.
- rd_we  in  1  write the ALU result to reg[rd].
- lit  in  DW  literal operand.
- cpc  in  2  PC control.
- call, ret, push, pop  in  1 each  stack commands.
- msel  in  log2(NREG)+1  read-mux select.
- muxout  out  DW  selected value.
- pc  out  DW  program counter.
- lnk  out  DW  link register.
- cee  out  DW  ALU result register.
- ceenz  out  1  compare flag.
- stk_full, stk_empty  out  1 each  stack status.
- err_ovf, err_unf  out  1 each  sticky stack error flags.

Function
REQ-005 A control word SHALL be accepted only in a cycle where op_valid=1 and op_ready=1; all other inputs are ignored otherwise.
REQ-006 The FSM SHALL have two states, IDLE and MUL. op_ready SHALL be 1 in IDLE and 0 in MUL.
REQ-007 The calu encodings SHALL be:
- 0 NOP
- 1 ADD rs1+rs2
- 2 SUB rs1-rs2
- 3 AND
- 4 OR
- 5 XOR
- 6 ADDI rs1+lit
- 7 SHL rs1 by 1
- 8 SHR rs1 by 1 (logical)
- 9 MOVI lit
- 10 MUL rs1*rs2
- 11-15 NOP
REQ-008 All arithmetic SHALL be modulo 2^DW: carries and borrows are discarded, and MUL keeps the low DW bits.
REQ-009 For every accepted op except NOP and MUL, cee SHALL update one cycle after acceptance. If rd_we=1, reg[rd] SHALL receive the same value in the same cycle. NOP leaves cee and all registers unchanged.
REQ-010 Accepting MUL SHALL move IDLE->MUL, latch the operands, and run a shift-add for exactly DW cycles. On the final cycle cee (and reg[rd] if rd_we was 1 at acceptance) SHALL be written and the FSM returns to IDLE. op_ready SHALL therefore be low for DW cycles.
REQ-011 ceenz SHALL be combinational: 1 when cee != lit, 0 when equal.
REQ-012 cpc SHALL act on acceptance:
- 00 hold
- 01 pc+1
- 10 pc<=lit
- 11 pc<=lit if ceenz=0, else pc+1
pc SHALL wrap modulo 2^DW. While in MUL, pc SHALL hold.
REQ-013 Exactly one stack command SHALL execute per accepted word, with priority call > ret > push > pop; lower-priority commands in the same word SHALL be ignored.
REQ-014 call SHALL push pc+1, set lnk<=pc+1, and set pc<=lit, overriding cpc.
REQ-015 ret SHALL pop the top entry into pc, overriding cpc.
REQ-016 push SHALL store reg[rs1] on the stack.
REQ-017 pop SHALL write the top entry to reg[rd]; this write overrides the ALU write to reg[rd] in the same word.
REQ-018 The stack SHALL be a LIFO of SDEPTH entries. stk_full=1 at SDEPTH entries; stk_empty=1 at 0 entries.
REQ-019 call or push when full SHALL leave the stack, pc, lnk and registers unchanged by the stack command and set err_ovf. cpc still applies for push; call is suppressed entirely.
REQ-020 ret or pop when empty SHALL leave the stack unchanged and set err_unf. For ret, pc holds; for pop, reg[rd] receives no stack data.
REQ-021 err_ovf and err_unf SHALL stay set until reset.
REQ-022 muxout SHALL equal reg[msel] when msel < NREG, and cee otherwise.
REQ-023 Register reads SHALL return pre-edge values; a same-word read-after-write sees the old value.

Reset
REQ-024 When rst=0, the block SHALL asynchronously clear all registers, pc, lnk, cee, the stack pointer, err_ovf and err_unf to 0, and force the FSM to IDLE.
REQ-025 Reset asserted mid-MUL SHALL abort the multiply without writing any result.
REQ-026 After reset: op_ready=1, stk_empty=1, stk_full=0, and ceenz = (lit != 0).

Verification
REQ-027 MOVI lit=0xF0 rd=1, then MOVI lit=0x20 rd=2, then ADD rd=3 -> reg[3]=0x10, cee=0x10 (carry dropped).
REQ-028 MUL of 0x0D*0x0B (DW=8) -> op_ready low 8 cycles, then cee=0x8F; a second op_valid held during MUL is accepted only after op_ready returns high.
REQ-029 pc=0x05, call with lit=0x40 -> pc=0x40, lnk=0x06; then ret -> pc=0x06, stk_empty=1.
REQ-030 Five pushes with SDEPTH=4 -> stk_full=1 after the 4th, err_ovf=1 after the 5th; four pops return values in reverse order; a 5th pop sets err_unf=1.
REQ-031 cee=0x33, lit=0x33, cpc=11 -> pc=0x33; with lit=0x34 -> pc increments.
REQ-032 rst pulsed low during cycle 3 of a MUL -> FSM IDLE, op_ready=1, cee=0, all registers 0.

Source files
------------

// File: rtl/varm_core_p.sv
// varm_core_p: register-file microcore with ALU, shift-add multiplier, PC control and a call/data stack.
module varm_core_p #(
  parameter int DW = 8,
  parameter int NREG = 8,
  parameter int SDEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    op_valid,
  output logic                    op_ready,
  input  logic [3:0]              calu,
  input  logic [$clog2(NREG)-1:0] rd,
  input  logic [$clog2(NREG)-1:0] rs1,
  input  logic [$clog2(NREG)-1:0] rs2,
  input  logic                    rd_we,
  input  logic [DW-1:0]           lit,
  input  logic [1:0]              cpc,
  input  logic                    call,
  input  logic                    ret,
  input  logic                    push,
  input  logic                    pop,
  input  logic [$clog2(NREG):0]   msel,
  output logic [DW-1:0]           muxout,
  output logic [DW-1:0]           pc,
  output logic [DW-1:0]           lnk,
  output logic [DW-1:0]           cee,
  output logic                    ceenz,
  output logic                    stk_full,
  output logic                    stk_empty,
  output logic                    err_ovf,
  output logic                    err_unf
);
  localparam int RW = $clog2(NREG);
  localparam int SW = $clog2(SDEPTH + 1);
  localparam int AW = $clog2(SDEPTH);
  localparam int CW = $clog2(DW + 1);
  localparam logic [CW-1:0] LAST = CW'(DW - 1);
  typedef enum logic {IDLE, MUL} state_t;
  state_t state, nstate;
  logic [DW-1:0] rf [NREG];
  logic [DW-1:0] stk [SDEPTH];
  logic [SW-1:0] sp;
  logic [DW-1:0] a, b, alu, top, pc_inc, pc_nx, ma, mb, mp, mp_nx;
  logic [CW-1:0] cnt;
  logic [RW-1:0] m_rd;
  logic          m_we, acc, alu_wr, is_mul, do_call, do_ret, do_push, do_pop;
  assign op_ready  = state == IDLE;
  assign acc       = op_valid && op_ready;
  assign is_mul    = calu == 4'd10;
  assign alu_wr    = calu != 4'd0 && calu <= 4'd9;
  assign stk_full  = sp == SW'(SDEPTH);
  assign stk_empty = sp == '0;
  assign ceenz     = cee != lit;
  assign muxout    = msel[RW] ? cee : rf[msel[RW-1:0]];
  assign top       = stk[AW'(sp - 1'b1)];
  assign pc_inc    = pc + 1'b1;
  assign mp_nx     = mp + (mb[0] ? ma : '0);
  assign do_call   = acc && call;
  assign do_ret    = acc && !call && ret;
  assign do_push   = acc && !call && !ret && push;
  assign do_pop    = acc && !call && !ret && !push && pop;
  always_comb begin
    a = rf[rs1];
    b = rf[rs2];
    alu = lit;
    case (calu)
      4'd1: alu = a + b;
      4'd2: alu = a - b;
      4'd3: alu = a & b;
      4'd4: alu = a | b;
      4'd5: alu = a ^ b;
      4'd6: alu = a + lit;
      4'd7: alu = a << 1;
      4'd8: alu = a >> 1;
      default: alu = lit;
    endcase
  end
  always_comb begin
    pc_nx = cpc == 2'b01 ? pc_inc : cpc == 2'b10 ? lit : cpc == 2'b11 ? (ceenz ? pc_inc : lit) : pc;
    pc_nx = do_call ? (stk_full ? pc : lit) : do_ret ? (stk_empty ? pc : top) : pc_nx;
  end
  always_comb begin
    nstate = state;
    if (state == IDLE) nstate = acc && is_mul ? MUL : IDLE;
    else nstate = cnt == LAST ? IDLE : MUL;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= nstate;
  // stack contents need no reset: sp alone defines which entries are live
  always_ff @(posedge clk)
    if (do_call && !stk_full) stk[AW'(sp)] <= pc_inc;
    else if (do_push && !stk_full) stk[AW'(sp)] <= rf[rs1];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
      pc <= '0;
      lnk <= '0;
      cee <= '0;
      sp <= '0;
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
      ma <= '0;
      mb <= '0;
      mp <= '0;
      cnt <= '0;
      m_rd <= '0;
      m_we <= 1'b0;
    end else if (acc) begin
      pc <= pc_nx;
      if (alu_wr) cee <= alu;
      if (alu_wr && rd_we) rf[rd] <= alu;
      if (is_mul) begin
        ma <= a;
        mb <= b;
        mp <= '0;
        cnt <= '0;
        m_rd <= rd;
        m_we <= rd_we;
      end
      if ((do_call || do_push) && stk_full) err_ovf <= 1'b1;
      if ((do_ret || do_pop) && stk_empty) err_unf <= 1'b1;
      if (do_call && !stk_full) lnk <= pc_inc;
      if ((do_call || do_push) && !stk_full) sp <= sp + 1'b1;
      if ((do_ret || do_pop) && !stk_empty) sp <= sp - 1'b1;
      if (do_pop && !stk_empty) rf[rd] <= top;
    end else if (state == MUL) begin
      ma <= ma << 1;
      mb <= mb >> 1;
      mp <= mp_nx;
      cnt <= cnt + 1'b1;
      if (cnt == LAST) cee <= mp_nx;
      if (cnt == LAST && m_we) rf[m_rd] <= mp_nx;
    end
endmodule

// File: tb/tb_varm_core_p.sv
// tb_varm_core_p: scoreboard bench; stimulus queues expected results, a negedge monitor checks them once op_ready is high.
module tb_varm_core_p;
  logic       clk = 1'b0, rst = 1'b0, op_valid = 1'b0, op_ready;
  logic [3:0] calu = '0;
  logic [2:0] rd = '0, rs1 = '0, rs2 = '0;
  logic       rd_we = 1'b0, call = 1'b0, ret = 1'b0, push = 1'b0, pop = 1'b0;
  logic [7:0] lit = '0, muxout, pc, lnk, cee;
  logic [1:0] cpc = '0;
  logic [3:0] msel = 4'd8;
  logic       ceenz, stk_full, stk_empty, err_ovf, err_unf;
  typedef struct {int kind; logic [31:0] val; string name;} exp_t;
  exp_t q[$];
  int asserts = 0, fails = 0, busy = 0, last_busy = 0;
  always #5 clk = ~clk;
  varm_core_p dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready), .calu(calu),
    .rd(rd), .rs1(rs1), .rs2(rs2), .rd_we(rd_we), .lit(lit), .cpc(cpc),
    .call(call), .ret(ret), .push(push), .pop(pop), .msel(msel), .muxout(muxout),
    .pc(pc), .lnk(lnk), .cee(cee), .ceenz(ceenz), .stk_full(stk_full),
    .stk_empty(stk_empty), .err_ovf(err_ovf), .err_unf(err_unf)
  );
  // kinds: 0 cee, 1 pc, 2 lnk, 3 muxout, 4 flags {ovf,unf,full,empty,ready,ceenz}, 5 busy cycles
  always @(negedge clk) begin
    exp_t e;
    logic [31:0] act;
    if (!op_ready) busy++;
    else begin
      if (busy != 0) last_busy = busy;
      busy = 0;
    end
    if (op_ready)
      while (q.size() != 0) begin
        e = q.pop_front();
        act = e.kind == 0 ? 32'(cee) : e.kind == 1 ? 32'(pc) : e.kind == 2 ? 32'(lnk) :
              e.kind == 3 ? 32'(muxout) : e.kind == 4 ? 32'({err_ovf, err_unf, stk_full, stk_empty, op_ready, ceenz}) :
              32'(last_busy);
        asserts++;
        if (act !== e.val) begin
          $display("FAIL %s: got %0h expected %0h", e.name, act, e.val);
          fails++;
        end
      end
  end
  task automatic ex(input int k, input logic [31:0] v, input string n);
    exp_t e;
    e.kind = k;
    e.val = v;
    e.name = n;
    q.push_back(e);
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      asserts++;
      fails++;
      q.delete();
    end
  endtask
  task automatic issue(input logic [3:0] c, input int d, input int s1, input int s2, input logic we,
                       input logic [7:0] l, input logic [1:0] pcc, input logic [3:0] cmd);
    int n = 0;
    @(negedge clk);
    calu = c;
    rd = 3'(d);
    rs1 = 3'(s1);
    rs2 = 3'(s2);
    rd_we = we;
    lit = l;
    cpc = pcc;
    {call, ret, push, pop} = cmd;
    op_valid = 1'b1;
    while (!op_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!op_ready) begin
      $display("FAIL issue_timeout: got ready 0 expected 1");
      asserts++;
      fails++;
    end
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    {call, ret, push, pop} = 4'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    #12 rst = 1'b1;
    ex(1, 0, "rst_pc"); ex(0, 0, "rst_cee"); ex(2, 0, "rst_lnk"); ex(4, 6'b000110, "rst_flags"); ex(3, 0, "rst_mux_cee");
    drain();
    lit = 8'h05;
    ex(4, 6'b000111, "rst_ceenz_lit"); drain();
    issue(9, 1, 0, 0, 1, 8'hF0, 0, 0);
    issue(9, 2, 0, 0, 1, 8'h20, 0, 0);
    issue(1, 3, 1, 2, 1, 8'h00, 0, 0);
    msel = 3; ex(0, 8'h10, "add_cee"); ex(3, 8'h10, "add_r3"); drain();
    msel = 1; ex(3, 8'hF0, "movi_r1"); drain();
    issue(2, 4, 2, 1, 1, 0, 0, 0);
    issue(7, 5, 1, 0, 1, 0, 0, 0);
    issue(8, 6, 1, 0, 0, 0, 0, 0);
    msel = 4; ex(3, 8'h30, "sub_r4"); ex(0, 8'h78, "shr_cee"); drain();
    msel = 5; ex(3, 8'hE0, "shl_r5"); drain();
    msel = 6; ex(3, 8'h00, "no_we_r6"); drain();
    issue(6, 0, 2, 0, 1, 8'hF0, 0, 0);
    issue(0, 0, 0, 0, 1, 8'h99, 0, 0);
    msel = 0; ex(3, 8'h10, "addi_r0"); ex(0, 8'h10, "nop_cee"); drain();
    issue(3, 0, 1, 2, 0, 0, 0, 0); ex(0, 8'h20, "and_cee"); drain();
    issue(5, 0, 1, 2, 0, 0, 0, 0); ex(0, 8'hD0, "xor_cee"); drain();
    issue(9, 6, 0, 0, 1, 8'h0D, 0, 0);
    issue(9, 7, 0, 0, 1, 8'h0B, 0, 0);
    issue(10, 5, 6, 7, 1, 0, 0, 0);
    msel = 5; ex(5, 8, "mul_busy"); ex(0, 8'h8F, "mul_cee"); ex(3, 8'h8F, "mul_r5");
    issue(6, 0, 7, 0, 1, 8'h01, 0, 0);
    ex(0, 8'h0C, "held_op_cee"); drain();
    issue(0, 0, 0, 0, 0, 8'h05, 2'b10, 0); ex(1, 8'h05, "jmp_pc"); drain();
    issue(0, 0, 0, 0, 0, 8'h40, 2'b01, 4'b1000);
    ex(1, 8'h40, "call_pc"); ex(2, 8'h06, "call_lnk"); ex(4, 6'b000011, "call_flags"); drain();
    issue(0, 0, 0, 0, 0, 8'h00, 2'b01, 4'b0100);
    ex(1, 8'h06, "ret_pc"); ex(4, 6'b000111, "ret_flags"); drain();
    issue(9, 0, 0, 0, 0, 8'h33, 0, 0); ex(0, 8'h33, "movi_nowe_cee"); drain();
    issue(0, 0, 0, 0, 0, 8'h10, 2'b10, 0);
    issue(0, 0, 0, 0, 0, 8'h34, 2'b11, 0); ex(1, 8'h11, "cbr_ne_pc"); drain();
    issue(0, 0, 0, 0, 0, 8'h33, 2'b11, 0); ex(1, 8'h33, "cbr_eq_pc"); drain();
    issue(0, 0, 0, 0, 0, 8'hFF, 2'b10, 0);
    issue(0, 0, 0, 0, 0, 8'h00, 2'b01, 0); ex(1, 8'h00, "pc_wrap"); drain();
    for (int i = 1; i <= 4; i++) issue(0, 0, i, 0, 0, 0, 0, 4'b0010);
    ex(4, 6'b001011, "push4_flags"); drain();
    issue(0, 0, 5, 0, 0, 0, 2'b01, 4'b0010);
    ex(4, 6'b101011, "push5_ovf"); ex(1, 8'h01, "push5_pc"); drain();
    msel = 0;
    issue(9, 0, 0, 0, 1, 8'h77, 0, 4'b0001); ex(3, 8'h30, "pop1_over_alu"); ex(0, 8'h77, "pop1_cee"); drain();
    issue(0, 0, 0, 0, 0, 0, 0, 4'b0001); ex(3, 8'h10, "pop2"); drain();
    issue(0, 0, 0, 0, 0, 0, 0, 4'b0001); ex(3, 8'h20, "pop3"); drain();
    issue(0, 0, 0, 0, 0, 0, 0, 4'b0001); ex(3, 8'hF0, "pop4"); ex(4, 6'b100111, "pop4_flags"); drain();
    issue(0, 0, 0, 0, 0, 0, 0, 4'b0001); ex(3, 8'hF0, "pop5_keep"); ex(4, 6'b110111, "pop5_unf"); drain();
    issue(10, 5, 6, 7, 1, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #3 rst = 1'b1;
    msel = 5;
    ex(4, 6'b000110, "abort_flags"); ex(0, 0, "abort_cee"); ex(1, 0, "abort_pc"); ex(3, 0, "abort_r5"); drain();
    msel = 1; ex(3, 0, "abort_r1"); drain();
    repeat (12) @(posedge clk);
    msel = 5; ex(0, 0, "abort_no_late_cee"); ex(3, 0, "abort_no_late_r5"); drain();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
